t01_ai_move_evaluator: RTL and testbench

T01_AI_MOVE_EVALUATOR -- requirements
Module: t01_ai_move_evaluator

---
 rtl/t01_ai_move_evaluator_pkg.sv | 36 +++
 rtl/t01_ai_move_evaluator_if.sv | 40 ++++
 rtl/t01_ai_move_evaluator_score_calc.sv | 38 +++
 rtl/t01_ai_move_evaluator.sv | 193 +++++++++++++++++++
 tb/tb_t01_ai_move_evaluator.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/t01_ai_move_evaluator_pkg.sv
// Shared types and constants for the AI move evaluator: FSM state encoding,
// field widths, score limits and default feature weights.
package t01_ai_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        REQ      = 3'd2,
        WAIT_ACK = 3'd3,
        WAIT_RES = 3'd4,
        SCORE    = 3'd5,
        RELEASE  = 3'd6,
        DONE     = 3'd7
    } eval_state_t;

    localparam int MAX_CANDIDATES = 40;
    localparam int SCORE_W        = 16;
    localparam int CAND_W         = 6;
    localparam int BOARD_W        = 200;
    localparam int LINES_W        = 3;
    localparam int FEAT_W         = 8;
    localparam int WAIT_CNT_W     = 6;

    localparam logic signed [SCORE_W-1:0] SCORE_MIN = 16'sh8000;

    localparam int DEF_W_LINES  = 16;
    localparam int DEF_W_HOLES  = 8;
    localparam int DEF_W_BUMP   = 2;
    localparam int DEF_W_HEIGHT = 1;

    // Requests above the list capacity are treated as a full list.
    function automatic logic [CAND_W-1:0] clamp_count(input logic [CAND_W-1:0] n);
        return (n > CAND_W'(MAX_CANDIDATES)) ? CAND_W'(MAX_CANDIDATES) : n;
    endfunction

endpackage

// File: rtl/t01_ai_move_evaluator_if.sv
// Candidate-board lookup and feature-extractor handshake bundle.
// master: the evaluator; slave: the board store plus feature extractor.
interface t01_ai_move_evaluator_if;
    import t01_ai_pkg::*;

    logic [CAND_W-1:0]  cand_idx;
    logic [BOARD_W-1:0] cand_board;
    logic               start_extract;
    logic [BOARD_W-1:0] next_board;
    logic               extract_ready;
    logic [LINES_W-1:0] feat_lines;
    logic [FEAT_W-1:0]  feat_holes;
    logic [FEAT_W-1:0]  feat_bump;
    logic [FEAT_W-1:0]  feat_height;

    modport master (
        output cand_idx,
        output start_extract,
        output next_board,
        input  cand_board,
        input  extract_ready,
        input  feat_lines,
        input  feat_holes,
        input  feat_bump,
        input  feat_height
    );

    modport slave (
        input  cand_idx,
        input  start_extract,
        input  next_board,
        output cand_board,
        output extract_ready,
        output feat_lines,
        output feat_holes,
        output feat_bump,
        output feat_height
    );

endinterface

// File: rtl/t01_ai_move_evaluator_score_calc.sv
// Combinational weighted sum of board features:
//   score = W_LINES*lines - W_HOLES*holes - W_BUMP*bump - W_HEIGHT*height
// evaluated in SCORE_W-bit two's complement with features zero-extended.
module t01_ai_score_calc
    import t01_ai_pkg::*;
#(
    parameter int W_LINES  = DEF_W_LINES,
    parameter int W_HOLES  = DEF_W_HOLES,
    parameter int W_BUMP   = DEF_W_BUMP,
    parameter int W_HEIGHT = DEF_W_HEIGHT
) (
    input  logic [LINES_W-1:0]        lines,
    input  logic [FEAT_W-1:0]         holes,
    input  logic [FEAT_W-1:0]         bump,
    input  logic [FEAT_W-1:0]         height,
    output logic signed [SCORE_W-1:0] score
);

    localparam logic signed [SCORE_W-1:0] WL = SCORE_W'(W_LINES);
    localparam logic signed [SCORE_W-1:0] WH = SCORE_W'(W_HOLES);
    localparam logic signed [SCORE_W-1:0] WB = SCORE_W'(W_BUMP);
    localparam logic signed [SCORE_W-1:0] WT = SCORE_W'(W_HEIGHT);

    logic signed [SCORE_W-1:0] lines_s;
    logic signed [SCORE_W-1:0] holes_s;
    logic signed [SCORE_W-1:0] bump_s;
    logic signed [SCORE_W-1:0] height_s;

    // Widen unsigned features into the signed score domain, then weight and sum
    always_comb begin
        lines_s  = signed'(SCORE_W'(lines));
        holes_s  = signed'(SCORE_W'(holes));
        bump_s   = signed'(SCORE_W'(bump));
        height_s = signed'(SCORE_W'(height));
        score    = (WL * lines_s) - (WH * holes_s) - (WB * bump_s) - (WT * height_s);
    end

endmodule

// File: rtl/t01_ai_move_evaluator.sv
// AI move evaluator: walks a list of candidate boards, sends each to an
// external feature extractor, scores the returned features and reports the
// highest-scoring candidate (ties keep the lower index).
// Optional build macro T01_AI_EVAL_TIMEOUT_EN adds an extractor watchdog that
// aborts a stalled evaluation and raises a sticky eval_error.
module t01_ai_move_evaluator
    import t01_ai_pkg::*;
#(
    parameter int W_LINES  = DEF_W_LINES,
    parameter int W_HOLES  = DEF_W_HOLES,
    parameter int W_BUMP   = DEF_W_BUMP,
    parameter int W_HEIGHT = DEF_W_HEIGHT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_eval,
    input  logic [CAND_W-1:0]         num_candidates,
    t01_ai_move_evaluator_if.master   ext,
    output logic                      busy,
    output logic                      eval_done,
    output logic [CAND_W-1:0]         best_idx,
    output logic signed [SCORE_W-1:0] best_score,
    output logic                      eval_error
);

    eval_state_t               state;
    logic [CAND_W-1:0]         count;
    logic [CAND_W-1:0]         cand_idx;
    logic [BOARD_W-1:0]        next_board;
    logic                      start_extract;
    logic [LINES_W-1:0]        lines_q;
    logic [FEAT_W-1:0]         holes_q;
    logic [FEAT_W-1:0]         bump_q;
    logic [FEAT_W-1:0]         height_q;
    logic signed [SCORE_W-1:0] score;

`ifdef T01_AI_EVAL_TIMEOUT_EN
    logic [WAIT_CNT_W-1:0]     wait_cnt;
    logic                      wait_expired;

    // Counter values 0..62 cover 63 stalled cycles in a wait state.
    assign wait_expired = (wait_cnt == WAIT_CNT_W'(62));
`else
    assign eval_error = 1'b0;
`endif

    assign ext.cand_idx      = cand_idx;
    assign ext.next_board    = next_board;
    assign ext.start_extract = start_extract;

    // Features are captured when ready is seen so SCORE does not depend on
    // the extractor holding its outputs after start_extract drops.
    t01_ai_score_calc #(
        .W_LINES  (W_LINES),
        .W_HOLES  (W_HOLES),
        .W_BUMP   (W_BUMP),
        .W_HEIGHT (W_HEIGHT)
    ) u_score_calc (
        .lines  (lines_q),
        .holes  (holes_q),
        .bump   (bump_q),
        .height (height_q),
        .score  (score)
    );

    // Evaluation sequencer: candidate walk, extractor handshake, best tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            cand_idx      <= '0;
            next_board    <= '0;
            start_extract <= 1'b0;
            lines_q       <= '0;
            holes_q       <= '0;
            bump_q        <= '0;
            height_q      <= '0;
            busy          <= 1'b0;
            eval_done     <= 1'b0;
            best_idx      <= '0;
            best_score    <= '0;
`ifdef T01_AI_EVAL_TIMEOUT_EN
            wait_cnt      <= '0;
            eval_error    <= 1'b0;
`endif
        end else begin
            eval_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_eval) begin
                        count      <= clamp_count(num_candidates);
                        cand_idx   <= '0;
                        best_idx   <= '0;
                        best_score <= SCORE_MIN;
                        busy       <= 1'b1;
`ifdef T01_AI_EVAL_TIMEOUT_EN
                        eval_error <= 1'b0;
`endif
                        if (num_candidates == '0) begin
                            eval_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state     <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    next_board    <= ext.cand_board;
                    start_extract <= 1'b1;
                    state         <= REQ;
                end

                REQ: begin
`ifdef T01_AI_EVAL_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state    <= WAIT_ACK;
                end

                WAIT_ACK: begin
                    if (!ext.extract_ready) begin
`ifdef T01_AI_EVAL_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        state    <= WAIT_RES;
                    end
`ifdef T01_AI_EVAL_TIMEOUT_EN
                    else if (wait_expired) begin
                        start_extract <= 1'b0;
                        eval_error    <= 1'b1;
                        eval_done     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
`endif
                end

                WAIT_RES: begin
                    if (ext.extract_ready) begin
                        lines_q       <= ext.feat_lines;
                        holes_q       <= ext.feat_holes;
                        bump_q        <= ext.feat_bump;
                        height_q      <= ext.feat_height;
                        start_extract <= 1'b0;
                        state         <= SCORE;
                    end
`ifdef T01_AI_EVAL_TIMEOUT_EN
                    else if (wait_expired) begin
                        start_extract <= 1'b0;
                        eval_error    <= 1'b1;
                        eval_done     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
`endif
                end

                SCORE: begin
                    if (score > best_score) begin
                        best_score <= score;
                        best_idx   <= cand_idx;
                    end
                    state <= RELEASE;
                end

                RELEASE: begin
                    if (cand_idx == count - CAND_W'(1)) begin
                        eval_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cand_idx  <= cand_idx + CAND_W'(1);
                        state     <= LOAD;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    start_extract <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t01_ai_move_evaluator.sv
// Self-checking bench for t01_ai_move_evaluator: a behavioural extractor and
// board store, plus a list-level reference model of the best-score search.
// Honours T01_AI_EVAL_TIMEOUT_EN for the stalled-extractor scenarios.
module tb_t01_ai_move_evaluator;

    localparam int REF_W_LINES  = 16;
    localparam int REF_W_HOLES  = 8;
    localparam int REF_W_BUMP   = 2;
    localparam int REF_W_HEIGHT = 1;
    localparam int NO_LIMIT     = 1000000;

    logic               clk = 1'b0;
    logic               reset;
    logic               start_eval;
    logic [5:0]         num_candidates;
    logic               busy;
    logic               eval_done;
    logic [5:0]         best_idx;
    logic signed [15:0] best_score;
    logic               eval_error;

    logic [199:0] boards [64];
    int f_lines [64];
    int f_holes [64];
    int f_bump [64];
    int f_height [64];

    int checks = 0;
    int errors = 0;
    int job_count = 0;
    int job_limit = NO_LIMIT;
    bit hold_low = 1'b0;

    t01_ai_move_evaluator_if bus ();

    t01_ai_move_evaluator dut (
        .clk            (clk),
        .reset          (reset),
        .start_eval     (start_eval),
        .num_candidates (num_candidates),
        .ext            (bus),
        .busy           (busy),
        .eval_done      (eval_done),
        .best_idx       (best_idx),
        .best_score     (best_score),
        .eval_error     (eval_error)
    );

    always #5 clk = ~clk;

    always_comb bus.cand_board = boards[bus.cand_idx];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [199:0] rand_board(input int i);
        logic [199:0] b = '0;
        for (int k = 0; k < 7; k++) b = {b[167:0], 32'($urandom())};
        b[5:0] = 6'(i);
        return b;
    endfunction

    task automatic set_cand(input int i, input int l, input int h, input int b, input int t);
        boards[i]   = rand_board(i);
        f_lines[i]  = l;
        f_holes[i]  = h;
        f_bump[i]   = b;
        f_height[i] = t;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++)
            set_cand(i, $urandom_range(0, 7), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    function automatic int ref_score(input int i);
        int s;
        logic signed [15:0] w;
        s = REF_W_LINES * f_lines[i] - REF_W_HOLES * f_holes[i]
          - REF_W_BUMP * f_bump[i] - REF_W_HEIGHT * f_height[i];
        w = 16'(s);
        return int'(w);
    endfunction

    // Best of the first 'scored' candidates; strict improvement only.
    task automatic model_best(input int scored, output int bi, output int bs);
        bs = -32768;
        bi = 0;
        for (int i = 0; i < scored; i++) begin
            if (ref_score(i) > bs) begin
                bs = ref_score(i);
                bi = i;
            end
        end
    endtask

    // Behavioural extractor: ack by dropping ready (after an optional delay that
    // leaves the previous result visible), then present fresh features with
    // ready held high until the next request.
    initial begin
        int idx;
        int guard;
        bus.extract_ready = 1'b0;
        bus.feat_lines    = '0;
        bus.feat_holes    = '0;
        bus.feat_bump     = '0;
        bus.feat_height   = '0;
        forever begin
            @(negedge clk);
            if (bus.start_extract === 1'b1 && job_count < job_limit) begin
                idx = int'(bus.cand_idx);
                check("next_board_at_req", bus.next_board === boards[idx], 1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                bus.extract_ready = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                bus.feat_lines    = 3'(f_lines[idx]);
                bus.feat_holes    = 8'(f_holes[idx]);
                bus.feat_bump     = 8'(f_bump[idx]);
                bus.feat_height   = 8'(f_height[idx]);
                bus.extract_ready = 1'b1;
                check("next_board_stable", bus.next_board === boards[idx], 1);
                job_count++;
                guard = 0;
                while (bus.start_extract === 1'b1 && guard < 200) begin
                    @(negedge clk);
                    guard++;
                end
            end else if (hold_low) begin
                bus.extract_ready = 1'b0;
            end
        end
    end

    task automatic run_eval(input int n_req, input int scored, input bit exp_err,
                            input bit inject, input int budget,
                            output int cycles, output bit any_start);
        int ebi;
        int ebs;
        bit seen;
        model_best(scored, ebi, ebs);
        @(negedge clk);
        num_candidates = 6'(n_req);
        start_eval     = 1'b1;
        cycles    = 0;
        seen      = 1'b0;
        any_start = 1'b0;
        while (!seen && cycles < budget) begin
            @(negedge clk);
            if (cycles == 0) start_eval = 1'b0;
            cycles++;
            if (bus.start_extract === 1'b1) any_start = 1'b1;
            if (eval_done === 1'b1) seen = 1'b1;
            if (inject && cycles == 6) begin
                num_candidates = 6'd1;
                start_eval     = 1'b1;
            end else if (inject && cycles == 7) begin
                start_eval = 1'b0;
            end
        end
        check("eval_done_seen", seen, 1);
        check("best_idx", best_idx, 6'(ebi));
        check("best_score", $unsigned(best_score), $unsigned(16'(ebs)));
        check("eval_error", eval_error, exp_err);
        check("busy_in_done", busy, 1);
        @(negedge clk);
        check("eval_done_pulse", eval_done, 0);
        check("busy_after_done", busy, 0);
        check("best_score_held", $unsigned(best_score), $unsigned(16'(ebs)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        bit anys;
        int n;
        bit no_done;

        reset          = 1'b1;
        start_eval     = 1'b0;
        num_candidates = '0;
        for (int i = 0; i < 64; i++) set_cand(i, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("rst_start_extract", bus.start_extract, 0);
        check("rst_next_board", bus.next_board === '0, 1);
        check("rst_cand_idx", bus.cand_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_eval_done", eval_done, 0);
        check("rst_best_idx", best_idx, 0);
        check("rst_best_score", $unsigned(best_score), 0);
        check("rst_eval_error", eval_error, 0);
        reset = 1'b0;

        // Empty list
        run_eval(0, 0, 1'b0, 1'b0, 10, cyc, anys);
        check("zero_latency", (cyc >= 1 && cyc <= 2), 1);
        check("zero_no_extract", anys, 0);
        check("zero_best_score", $unsigned(best_score), 16'h8000);

        // Directed three-candidate list
        set_cand(0, 0, 2, 4, 10);
        set_cand(1, 1, 0, 2, 8);
        set_cand(2, 0, 0, 0, 4);
        run_eval(3, 3, 1'b0, 1'b0, 500, cyc, anys);
        check("directed_idx", best_idx, 1);
        check("directed_score", $unsigned(best_score), 16'd4);

        // Tie keeps the lower index
        set_cand(0, 0, 1, 0, 0);
        set_cand(1, 0, 1, 0, 0);
        set_cand(2, 0, 3, 0, 0);
        run_eval(3, 3, 1'b0, 1'b0, 500, cyc, anys);
        check("tie_idx", best_idx, 0);

        // Randomized lists; one run pulses start_eval mid-evaluation
        for (int r = 0; r < 6; r++) begin
            n = (r == 2) ? $urandom_range(12, 40) : $urandom_range(1, 40);
            fill_random(n);
            run_eval(n, n, 1'b0, (r == 2), 2000, cyc, anys);
        end

        // Oversized count clamps to 40
        fill_random(64);
        n = $urandom_range(41, 63);
        run_eval(n, 40, 1'b0, 1'b0, 2000, cyc, anys);

        // Reset while waiting for a result, then a fresh evaluation
        job_limit = job_count;
        hold_low  = 1'b1;
        @(negedge clk);
        num_candidates = 6'd2;
        start_eval     = 1'b1;
        @(negedge clk);
        start_eval = 1'b0;
        repeat (8) @(negedge clk);
        check("stall_start_extract", bus.start_extract, 1);
        check("stall_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_start_extract", bus.start_extract, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cand_idx", bus.cand_idx, 0);
        @(negedge clk);
        reset     = 1'b0;
        hold_low  = 1'b0;
        job_limit = NO_LIMIT;
        fill_random(2);
        run_eval(2, 2, 1'b0, 1'b0, 500, cyc, anys);

`ifdef T01_AI_EVAL_TIMEOUT_EN
        // Extractor goes silent after two jobs; stale ready stays high
        fill_random(4);
        job_limit = job_count + 2;
        run_eval(4, 2, 1'b1, 1'b0, 400, cyc, anys);
        check("tmo_ack_start_extract", bus.start_extract, 0);

        // Extractor never raises ready
        job_limit = job_count;
        hold_low  = 1'b1;
        run_eval(1, 0, 1'b1, 1'b0, 200, cyc, anys);
        check("tmo_res_cycles", (cyc >= 64 && cyc <= 70), 1);
        repeat (5) @(negedge clk);
        check("eval_error_sticky", eval_error, 1);
        hold_low  = 1'b0;
        job_limit = NO_LIMIT;
        fill_random(3);
        run_eval(3, 3, 1'b0, 1'b0, 500, cyc, anys);
`else
        // Extractor never raises ready: the evaluator keeps waiting
        job_limit = job_count;
        hold_low  = 1'b1;
        @(negedge clk);
        num_candidates = 6'd1;
        start_eval     = 1'b1;
        @(negedge clk);
        start_eval = 1'b0;
        no_done    = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (eval_done === 1'b1) no_done = 1'b0;
        end
        check("hang_busy", busy, 1);
        check("hang_no_done", no_done, 1);
        check("hang_start_extract", bus.start_extract, 1);
        check("hang_eval_error", eval_error, 0);
        #2 reset = 1'b1;
        #1;
        check("hang_rst_busy", busy, 0);
        @(negedge clk);
        reset     = 1'b0;
        hold_low  = 1'b0;
        job_limit = NO_LIMIT;
        fill_random(3);
        run_eval(3, 3, 1'b0, 1'b0, 500, cyc, anys);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
